// File: rtl/gpreg_file_sb_pkg.sv
// Shared register-file definitions used by decode, issue and writeback.
package gpreg_file_sb_pkg;

  localparam int          GPR_DATA_W   = 8;
  localparam int          GPR_NUM_REGS = 32;
  localparam int          GPR_ADDR_W   = 5;
  localparam int unsigned ZERO_ADDR    = 0;

  // True when the address names a physically present register.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned num_regs);
    return (addr < num_regs);
  endfunction

  // True when a write or issue to this address has an architectural effect.
  function automatic logic addr_writable(input logic [31:0] addr,
                                         input int unsigned num_regs,
                                         input bit          zero_reg);
    return addr_in_range(addr, num_regs) && !(zero_reg && (addr == ZERO_ADDR));
  endfunction

endpackage

// File: rtl/gpreg_file_sb_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, and a
// same-cycle writeback masks the hazard seen by the read ports.
module gpreg_scoreboard
  import gpreg_file_sb_pkg::*;
#(
  parameter int NUM_REGS = GPR_NUM_REGS,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic              ra_busy,
  output logic              rb_busy,
  output logic              busy_any
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_issue_ok;
  logic                w_clear_ok;

  assign w_issue_ok = issue_en && addr_writable(32'(issue_addr), NUM_REGS, ZERO_REG);
  assign w_clear_ok = wr_en    && addr_writable(32'(wr_addr),    NUM_REGS, ZERO_REG);

  // Next busy vector: a new issue overrides a writeback to the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_issue_ok && (32'(issue_addr) == 32'(i)))
        w_busy_nxt[i] = 1'b1;
      else if (w_clear_ok && (32'(wr_addr) == 32'(i)))
        w_busy_nxt[i] = 1'b0;
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // Hazard outputs: out-of-range is never busy, same-cycle writeback clears.
  always_comb begin
    ra_busy  = addr_in_range(32'(ra_addr), NUM_REGS) && r_busy[ra_addr] &&
               !(wr_en && (wr_addr == ra_addr));
    rb_busy  = addr_in_range(32'(rb_addr), NUM_REGS) && r_busy[rb_addr] &&
               !(wr_en && (wr_addr == rb_addr));
    busy_any = |r_busy;
  end

endmodule

// File: rtl/gpreg_file_sb.sv
// General-purpose register file: two registered read ports with write-first
// forwarding, one write port, optional hardwired zero register, busy scoreboard.
// Read handshake: rd_en is a one-cycle request; rd_valid is high exactly one
// cycle later and ra_data/rb_data hold until the next accepted rd_en.
module gpreg_file_sb
  import gpreg_file_sb_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = GPR_NUM_REGS,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              ra_busy,
  output logic              rb_busy,
  output logic              busy_any
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [DATA_W-1:0] r_ra_data;
  logic [DATA_W-1:0] r_rb_data;
  logic              r_rd_valid;
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_ra_val;
  logic [DATA_W-1:0] w_rb_val;

  assign w_wr_ok = wr_en && addr_writable(32'(wr_addr), NUM_REGS, ZERO_REG);

  // Storage array; ignored writes (out of range, zero register) never land.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Port A value: range, zero register, forwarding, then storage.
  always_comb begin
    w_ra_val = '0;
    if (!addr_in_range(32'(ra_addr), NUM_REGS))          w_ra_val = '0;
    else if (ZERO_REG && (ra_addr == ADDR_W'(ZERO_ADDR))) w_ra_val = '0;
    else if (w_wr_ok && (wr_addr == ra_addr))             w_ra_val = wr_data;
    else                                                  w_ra_val = r_mem[ra_addr];
  end

  // Port B value: same resolution order as port A.
  always_comb begin
    w_rb_val = '0;
    if (!addr_in_range(32'(rb_addr), NUM_REGS))          w_rb_val = '0;
    else if (ZERO_REG && (rb_addr == ADDR_W'(ZERO_ADDR))) w_rb_val = '0;
    else if (w_wr_ok && (wr_addr == rb_addr))             w_rb_val = wr_data;
    else                                                  w_rb_val = r_mem[rb_addr];
  end

  // Read output registers; data holds when no read is requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ra_data  <= '0;
      r_rb_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_ra_data <= w_ra_val;
        r_rb_data <= w_rb_val;
      end
    end
  end

  assign ra_data  = r_ra_data;
  assign rb_data  = r_rb_data;
  assign rd_valid = r_rd_valid;

  gpreg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .ra_busy    (ra_busy),
    .rb_busy    (rb_busy),
    .busy_any   (busy_any)
  );

endmodule

// File: tb/tb_gpreg_file_sb.sv
// Directed plus short random test of gpreg_file_sb with a read-data queue.
module tb_gpreg_file_sb;

  localparam int DW = 8;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en;
  logic [AW-1:0] ra_addr, rb_addr;
  logic [DW-1:0] ra_data, rb_data;
  logic          rd_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic          ra_busy, rb_busy, busy_any;

  // Model state
  logic [DW-1:0] m_reg [NR];
  logic [NR-1:0] m_busy;
  logic [DW-1:0] last_a, last_b;
  logic [DW-1:0] exp_q [$];

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // clock / reset block
  always #5 clk = ~clk;

  gpreg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .ra_busy(ra_busy), .rb_busy(rb_busy), .busy_any(busy_any)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && (wr_addr == a)) return wr_data;
    return m_reg[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    m_busy = '0;
    last_a = '0;
    last_b = '0;
    exp_q.delete();
  endtask

  // driver: apply one cycle of inputs, let combinational outputs settle
  task automatic drive(input logic rd, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia);
    rd_en = rd; ra_addr = ra; rb_addr = rb;
    wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_addr = ia;
    #1;
  endtask

  // combinational busy checks against the model
  task automatic check_busy();
    check("ra_busy",  {31'd0, ra_busy},
          {31'd0, m_busy[ra_addr] && !(wr_en && wr_addr == ra_addr)});
    check("rb_busy",  {31'd0, rb_busy},
          {31'd0, m_busy[rb_addr] && !(wr_en && wr_addr == rb_addr)});
    check("busy_any", {31'd0, busy_any}, {31'd0, |m_busy});
  endtask

  // clock edge: push expected reads, update model, compare after the edge
  task automatic tick();
    logic          exp_valid;
    logic [DW-1:0] ea, eb;
    exp_valid = rd_en;
    if (rd_en) begin
      exp_q.push_back(mread(ra_addr));
      exp_q.push_back(mread(rb_addr));
    end
    if (wr_en && wr_addr != 0) begin
      m_reg[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    @(posedge clk);
    #1;
    check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      if (exp_q.size() < 2) begin
        check("exp_q_underflow", exp_q.size(), 2);
      end else begin
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        check("ra_data", ra_data, ea);
        check("rb_data", rb_data, eb);
        last_a = ea;
        last_b = eb;
      end
    end else begin
      check("ra_hold", ra_data, last_a);
      check("rb_hold", rb_data, last_b);
    end
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b1;
    rd_en = 0; ra_addr = 0; rb_addr = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    issue_en = 0; issue_addr = 0;
    model_reset();
    #2;
    check("reset_ra_data",  ra_data, 0);
    check("reset_rb_data",  rb_data, 0);
    check("reset_rd_valid", {31'd0, rd_valid}, 0);
    check("reset_busy_any", {31'd0, busy_any}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // read r5/r31 after reset
    drive(1'b1, 5'd5, 5'd31, 1'b0, '0, '0, 1'b0, '0);
    check_busy();
    tick();
    check("post_reset_ra", ra_data, 8'h00);
    check("post_reset_rb", rb_data, 8'h00);
    check("post_reset_valid", {31'd0, rd_valid}, 1);

    // write r3 = A5, then read both ports
    drive(1'b0, '0, '0, 1'b1, 5'd3, 8'hA5, 1'b0, '0);
    tick();
    drive(1'b1, 5'd3, 5'd3, 1'b0, '0, '0, 1'b0, '0);
    tick();
    check("r3_a", ra_data, 8'hA5);
    check("r3_b", rb_data, 8'hA5);

    // forwarding: r7 = 11, then same-cycle write 3C with read
    drive(1'b0, '0, '0, 1'b1, 5'd7, 8'h11, 1'b0, '0);
    tick();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 8'h3C, 1'b0, '0);
    tick();
    check("fwd_r7_a", ra_data, 8'h3C);
    check("fwd_r7_b", rb_data, 8'h3C);
    idle();
    tick();

    // zero register ignores writes and issues
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 8'hFF, 1'b0, '0);
    tick();
    check("r0_fwd_blocked", ra_data, 8'h00);
    drive(1'b1, 5'd0, 5'd7, 1'b0, '0, '0, 1'b1, 5'd0);
    tick();
    check("r0_read", ra_data, 8'h00);
    idle();
    check("r0_issue_busy_any", {31'd0, busy_any}, 0);

    // scoreboard on r4
    drive(1'b0, 5'd4, 5'd4, 1'b0, '0, '0, 1'b1, 5'd4);
    tick();
    drive(1'b0, 5'd4, 5'd4, 1'b0, '0, '0, 1'b0, '0);
    check("r4_busy", {31'd0, ra_busy}, 1);
    check_busy();
    drive(1'b0, 5'd4, 5'd4, 1'b1, 5'd4, 8'h55, 1'b0, '0);
    check("r4_wb_mask", {31'd0, ra_busy}, 0);
    check("r4_wb_busy_any", {31'd0, busy_any}, 1);
    check_busy();
    tick();
    drive(1'b0, 5'd4, 5'd4, 1'b0, '0, '0, 1'b0, '0);
    check("r4_cleared", {31'd0, ra_busy}, 0);
    check_busy();
    drive(1'b0, 5'd4, 5'd4, 1'b1, 5'd4, 8'h66, 1'b1, 5'd4);
    tick();
    drive(1'b1, 5'd4, 5'd3, 1'b0, '0, '0, 1'b0, '0);
    check("r4_issue_wins", {31'd0, ra_busy}, 1);
    check_busy();
    tick();

    // async reset mid-cycle after writes and issues
    drive(1'b1, 5'd9, 5'd10, 1'b1, 5'd9, 8'h77, 1'b1, 5'd12);
    tick();
    drive(1'b1, 5'd3, 5'd9, 1'b1, 5'd10, 8'h88, 1'b1, 5'd13);
    #2;
    reset = 1'b1;
    #1;
    check("async_ra_data",  ra_data, 0);
    check("async_rb_data",  rb_data, 0);
    check("async_rd_valid", {31'd0, rd_valid}, 0);
    check("async_busy_any", {31'd0, busy_any}, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NR / 2; i++) begin
      drive(1'b1, AW'(2 * i), AW'(2 * i + 1), 1'b0, '0, '0, 1'b0, '0);
      check_busy();
      tick();
    end

    // random traffic
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), DW'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)));
      check_busy();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpreg_file_sb.md
Name: gpreg_file_sb

Overview:
Parametrised general-purpose register file with a per-register busy scoreboard, the next-generation CPU register block.
- Two registered read ports and one write port.
- Write-first forwarding, so a read and a write can occur in the same cycle.
- Optional hardwired zero register.
- Busy bits let the issue stage detect operands still awaiting writeback.
- Sits between decode/issue and the ALU; writeback drives the write port.

Parameters:
DATA_W, 8, register width in bits
NUM_REGS, 32, number of registers (2..256)
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= NUM_REGS
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
rd_en  in  1  capture both read ports this cycle
ra_addr  in  ADDR_W  read port A address
rb_addr  in  ADDR_W  read port B address
ra_data  out  DATA_W  registered read data A
rb_data  out  DATA_W  registered read data B
rd_valid  out  1  ra_data/rb_data updated by the previous cycle's rd_en
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
issue_en  in  1  mark issue_addr busy (producer issued)
issue_addr  in  ADDR_W  destination register being issued
ra_busy  out  1  combinational: ra_addr is awaiting writeback
rb_busy  out  1  combinational: rb_addr is awaiting writeback
busy_any  out  1  combinational: OR of all busy bits

Behaviour:
- Reset (async, clk-independent) sets:
  - all registers to 0 and all busy bits to 0;
  - ra_data = rb_data = 0 and rd_valid = 0 (no X outputs).
- Write: at posedge with wr_en=1, regfile[wr_addr] <= wr_data. Ignored when:
  - wr_addr >= NUM_REGS, or
  - ZERO_REG=1 and wr_addr=0.
- Read (latency 1):
  - At posedge with rd_en=1, ra_data <= value of regfile[ra_addr]; rb_data likewise from rb_addr.
  - rd_valid <= rd_en every cycle.
  - When rd_en=0, ra_data and rb_data hold their previous values.
- Read value resolution, in priority order:
  1. Out-of-range address reads 0.
  2. ZERO_REG=1 and address 0 reads 0.
  3. wr_en=1 with wr_addr equal to the read address (and the write not ignored) forwards wr_data.
  4. Otherwise the stored value.
- Simultaneous: both read ports may hit the same address, and both may forward the same write.
- Scoreboard, per register, at posedge:
  - issue_en sets busy[issue_addr];
  - wr_en clears busy[wr_addr];
  - issue and write to the same address in one cycle: busy stays 1 (new producer wins);
  - issue to an ignored address (out of range, or reg 0 with ZERO_REG=1): no effect.
- Busy outputs:
  - ra_busy = busy[ra_addr] AND NOT (wr_en AND wr_addr==ra_addr), i.e. a same-cycle writeback clears the hazard. rb_busy likewise.
  - Out-of-range addresses report not busy.
  - busy_any reflects registered busy bits only.
- Reset mid-operation: in-flight reads are discarded (rd_valid=0); a write or issue in the reset cycle is lost.
- No X propagation: every output is defined whenever reset has been asserted once.

Decomposition:
- Shared package (CPU-wide, used by decode and writeback):
  - DATA_W, NUM_REGS, ADDR_W defaults;
  - ZERO_ADDR constant;
  - a function for the address-valid check.
- One sub-module, gpreg_scoreboard: holds the busy vector; issue/clear logic; ra_busy, rb_busy and busy_any.
- Storage, forwarding and read registers stay in the top level.

Test Plan:
- Reset then rd_en=1, ra_addr=5, rb_addr=31 -> next cycle ra_data=0x00, rb_data=0x00, rd_valid=1; ra_busy=rb_busy=busy_any=0.
- Write 0xA5 to r3; next cycle read r3 on both ports -> ra_data=rb_data=0xA5 one cycle after rd_en.
- Same cycle: wr_en with r7=0x3C, rd_en with ra_addr=7, r7 previously 0x11 -> ra_data=0x3C (forwarded).
- ZERO_REG=1: write 0xFF to r0, then read r0 -> 0x00; issue_en on r0 -> busy_any stays 0.
- Issue r4 -> ra_busy=1 with ra_addr=4 from next cycle; cycle with wr_en to r4 -> ra_busy=0 combinationally, busy bit cleared after the edge. Issue and write to r4 in the same cycle -> busy stays 1.
- Assert reset asynchronously mid-cycle after writes and issues -> ra_data, rb_data and rd_valid go to 0 immediately; busy_any=0; all registers read 0 afterwards.
